// File: rtl/ysyx_22040729_pkg.sv
// Shared types for the ysyx_22040729 decode stage: type codes, opcode[6:2] constants,
// the decoded-entry struct and the skid-buffer state encoding.
package ysyx_22040729_pkg;

   typedef enum logic [2:0] {
      TYPE_NONE = 3'd0,
      TYPE_R    = 3'd1,
      TYPE_I    = 3'd2,
      TYPE_S    = 3'd3,
      TYPE_B    = 3'd4,
      TYPE_U    = 3'd5,
      TYPE_J    = 3'd6,
      TYPE_SPEC = 3'd7
   } inst_type_e;

   localparam logic [4:0] OP_LOAD     = 5'b00000;
   localparam logic [4:0] OP_MISC_MEM = 5'b00011;
   localparam logic [4:0] OP_OP_IMM   = 5'b00100;
   localparam logic [4:0] OP_AUIPC    = 5'b00101;
   localparam logic [4:0] OP_IMM_32   = 5'b00110;
   localparam logic [4:0] OP_STORE    = 5'b01000;
   localparam logic [4:0] OP_OP       = 5'b01100;
   localparam logic [4:0] OP_LUI      = 5'b01101;
   localparam logic [4:0] OP_OP_32    = 5'b01110;
   localparam logic [4:0] OP_BRANCH   = 5'b11000;
   localparam logic [4:0] OP_JALR     = 5'b11001;
   localparam logic [4:0] OP_JAL      = 5'b11011;
   localparam logic [4:0] OP_SYSTEM   = 5'b11100;

   // pc/imm are carried at the widest XLEN; narrower builds use the low bits.
   typedef struct packed {
      logic [63:0] pc;
      inst_type_e  itype;
      logic        rf_we;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  opcode;
      logic [63:0] imm;
      logic        illegal;
      logic        muldiv;
   } dec_entry_t;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_e;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/ysyx_22040729_decode_stage_if.sv
// IFU->decode and decode->EXU handshake bundle. master = environment side, slave = decode stage.
interface ysyx_22040729_decode_stage_if #(
   parameter int INST_WIDTH = 32,
   parameter int DATA_WIDTH = 64
);
   logic                  in_valid;
   logic                  in_ready;
   logic [INST_WIDTH-1:0] in_inst;
   logic [DATA_WIDTH-1:0] in_pc;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_pc;
   logic [2:0]            out_type;
   logic                  out_rf_we;
   logic [4:0]            out_rd;
   logic [4:0]            out_rs1;
   logic [4:0]            out_rs2;
   logic [2:0]            out_funct3;
   logic [6:0]            out_opcode;
   logic [DATA_WIDTH-1:0] out_imm;
   logic                  out_illegal;
   logic                  out_muldiv;

   modport master (
      output in_valid, in_inst, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_type, out_rf_we, out_rd, out_rs1, out_rs2,
             out_funct3, out_opcode, out_imm, out_illegal, out_muldiv
   );

   modport slave (
      input  in_valid, in_inst, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_type, out_rf_we, out_rd, out_rs1, out_rs2,
             out_funct3, out_opcode, out_imm, out_illegal, out_muldiv
   );
endinterface

// File: rtl/ysyx_22040729_decode_comb.sv
// Pure combinational RV32I/RV64I decoder: instruction word + pc -> decoded entry.
// Define YSYX_22040729_RV_M_EN to accept M-extension ops (funct7=0000001) in OP/OP-32.
module ysyx_22040729_decode_comb
   import ysyx_22040729_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic [31:0]           inst,
   input  logic [DATA_WIDTH-1:0] pc,
   output dec_entry_t            entry
);

   logic [4:0] op5;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic       r_std_ok;
   logic       muldiv;
   logic       r_bad;
   inst_type_e itype;
   logic       illegal;
   logic       rf_we;
   logic [31:0] imm32;

   assign op5      = inst[6:2];
   assign funct7   = inst[31:25];
   assign funct3   = inst[14:12];
   assign r_std_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

   always_comb begin
      itype = TYPE_NONE;
      case (op5)
         OP_LUI, OP_AUIPC:                          itype = TYPE_U;
         OP_JAL:                                    itype = TYPE_J;
         OP_JALR, OP_LOAD, OP_OP_IMM, OP_MISC_MEM:  itype = TYPE_I;
         OP_STORE:                                  itype = TYPE_S;
         OP_BRANCH:                                 itype = TYPE_B;
         OP_OP:                                     itype = TYPE_R;
         OP_IMM_32:  itype = (DATA_WIDTH == 64) ? TYPE_I : TYPE_NONE;
         OP_OP_32:   itype = (DATA_WIDTH == 64) ? TYPE_R : TYPE_NONE;
         OP_SYSTEM:                                 itype = TYPE_SPEC;
         default:                                   itype = TYPE_NONE;
      endcase
   end

`ifdef YSYX_22040729_RV_M_EN
   // OP-32 only has the word forms MULW/DIVW/DIVUW/REMW/REMUW.
   assign muldiv = (itype == TYPE_R) && (funct7 == 7'b0000001) &&
                   ((op5 != OP_OP_32) || (funct3 == 3'b000) || funct3[2]);
`else
   assign muldiv = 1'b0;
`endif

   assign r_bad   = (itype == TYPE_R) && !r_std_ok && !muldiv;
   assign illegal = (inst[1:0] != 2'b11) || (itype == TYPE_NONE) || r_bad;

   always_comb begin
      rf_we = 1'b0;
      case (itype)
         TYPE_R, TYPE_I, TYPE_U, TYPE_J: rf_we = (op5 != OP_MISC_MEM);
         TYPE_SPEC:                      rf_we = (funct3 != 3'b000);
         default:                        rf_we = 1'b0;
      endcase
      if (inst[11:7] == 5'd0 || illegal) rf_we = 1'b0;
   end

   always_comb begin
      imm32 = {{20{inst[31]}}, inst[31:20]};
      case (itype)
         TYPE_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         TYPE_B: imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
         TYPE_U: imm32 = {inst[31:12], 12'b0};
         TYPE_J: imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm32 = {{20{inst[31]}}, inst[31:20]};
      endcase
   end

   always_comb begin
      entry         = '0;
      entry.pc      = 64'(pc);
      entry.itype   = itype;
      entry.rf_we   = rf_we;
      entry.rd      = inst[11:7];
      entry.rs1     = inst[19:15];
      entry.rs2     = inst[24:20];
      entry.funct3  = funct3;
      entry.opcode  = inst[6:0];
      entry.imm     = sext32(imm32);
      entry.illegal = illegal;
      entry.muldiv  = muldiv;
   end

endmodule

// File: rtl/ysyx_22040729_decode_stage.sv
// Registered decode stage with a 2-entry skid buffer so in_ready comes straight from a flop.
// Optional M-extension decode is enabled by defining YSYX_22040729_RV_M_EN.
module ysyx_22040729_decode_stage
   import ysyx_22040729_pkg::*;
#(
   parameter int INST_WIDTH = 32,
   parameter int DATA_WIDTH = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   ysyx_22040729_decode_stage_if.slave   bus,
   output buf_state_e                    dbg_state
);

   // Handshake: a beat transfers on a rising edge where valid & ready are both high.
   // in_ready depends only on registered state; the head payload holds while out_valid & !out_ready.

   buf_state_e            state_q, state_d;
   logic                  in_ready_q;
   dec_entry_t            head_q, tail_q, new_entry;
   logic [INST_WIDTH-1:0] inst_w;
   logic                  accept, pop;
   logic                  out_valid;
   logic                  head_ld_new, head_ld_tail, tail_ld;

   assign inst_w = bus.in_inst;

   ysyx_22040729_decode_comb #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
      .inst  (inst_w),
      .pc    (bus.in_pc),
      .entry (new_entry)
   );

   assign accept = bus.in_valid & in_ready_q;
   assign pop    = (state_q != BUF_EMPTY) & bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BUF_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != BUF_FULL);
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = BUF_EMPTY;
      end else begin
         case (state_q)
            BUF_EMPTY: if (accept) state_d = BUF_ONE;
            BUF_ONE: begin
               if (accept && !pop)      state_d = BUF_FULL;
               else if (pop && !accept) state_d = BUF_EMPTY;
            end
            BUF_FULL:  if (pop) state_d = BUF_ONE;
            default:   state_d = BUF_EMPTY;
         endcase
      end
   end

   // Payload steering; a flush cycle loads nothing so the discarded accept never lands.
   always_comb begin
      out_valid    = (state_q != BUF_EMPTY);
      head_ld_new  = 1'b0;
      head_ld_tail = 1'b0;
      tail_ld      = 1'b0;
      if (!flush) begin
         case (state_q)
            BUF_EMPTY: head_ld_new = accept;
            BUF_ONE: begin
               head_ld_new = accept & pop;
               tail_ld     = accept & ~pop;
            end
            BUF_FULL:  head_ld_tail = pop;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         if (head_ld_new)       head_q <= new_entry;
         else if (head_ld_tail) head_q <= tail_q;
         if (tail_ld)           tail_q <= new_entry;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid;
   assign bus.out_pc      = head_q.pc[DATA_WIDTH-1:0];
   assign bus.out_type    = head_q.itype;
   assign bus.out_rf_we   = head_q.rf_we;
   assign bus.out_rd      = head_q.rd;
   assign bus.out_rs1     = head_q.rs1;
   assign bus.out_rs2     = head_q.rs2;
   assign bus.out_funct3  = head_q.funct3;
   assign bus.out_opcode  = head_q.opcode;
   assign bus.out_imm     = head_q.imm[DATA_WIDTH-1:0];
   assign bus.out_illegal = head_q.illegal;
   assign bus.out_muldiv  = head_q.muldiv;
   assign dbg_state       = state_q;

endmodule
